// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-wide RAM port controller.
// MEM_IO_STALL_EN (see mem_ctrl.sv) uses IO_BASE to find the I/O region.
package mem_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    // Addresses at or above this belong to the memory-mapped I/O region
    localparam logic [ADDR_W-1:0] IO_BASE = 32'h0003_0000;

    // Access length codes as presented on mem_len_in
    localparam logic [2:0] LEN_B = 3'b000;
    localparam logic [2:0] LEN_H = 3'b001;
    localparam logic [2:0] LEN_W = 3'b011;

    // busy_out encodings
    localparam logic [1:0] BUSY_IDLE = 2'b00;
    localparam logic [1:0] BUSY_IF   = 2'b01;
    localparam logic [1:0] BUSY_MEM  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IF_RD  = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_GAP    = 3'd4
    } state_e;

    // Byte count for a length code; unknown codes behave as a word
    function automatic logic [CNT_W-1:0] len_bytes(input logic [2:0] len);
        case (len)
            LEN_B:   return CNT_W'(1);
            LEN_H:   return CNT_W'(2);
            default: return CNT_W'(4);
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbiter/sequencer for the shared byte-wide RAM port (IF fetch vs. mem stage).
// MEM accesses have priority and preempt an in-flight fetch.
// Optional feature: define MEM_IO_STALL_EN to hold I/O-region store bytes while io_full_in=1.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              if_req_in,
    input  logic [ADDR_W-1:0] if_addr_in,
    output logic              if_done_out,
    output logic [DATA_W-1:0] if_inst_out,
    input  logic              read_req_in,
    input  logic              write_req_in,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [DATA_W-1:0] mem_val_in,
    input  logic [2:0]        mem_len_in,
    output logic              mem_done_out,
    output logic [DATA_W-1:0] mem_val_read_out,
    output logic [1:0]        busy_out,
    input  logic [BYTE_W-1:0] ram_din_in,
    output logic [ADDR_W-1:0] ram_a_out,
    output logic              ram_wr_out,
    output logic [BYTE_W-1:0] ram_dout_out,
    input  logic              io_full_in
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic              ram_wr_q, ram_wr_d;
    logic [BYTE_W-1:0] ram_dout_q, ram_dout_d;
    logic              if_done_q, if_done_d;
    logic [DATA_W-1:0] if_inst_q, if_inst_d;
    logic              mem_done_q, mem_done_d;
    logic [DATA_W-1:0] mem_val_q, mem_val_d;
    logic [1:0]        busy_q, busy_d;

    logic              mem_req_c;
    logic              accept_mem_c;
    logic              accept_if_c;
    logic              rd_step_c;
    logic              io_stall_c;
    logic [ADDR_W-1:0] byte_addr_c;
    logic [BYTE_W-1:0] wbyte_c;
    logic [DATA_W-1:0] asm_shift_c;
    logic [5:0]        pad_sh_c;
    logic [CNT_W-1:0]  n_last_c;

`ifdef MEM_IO_STALL_EN
    // An I/O-region store byte waits while the I/O write buffer is full
    assign io_stall_c = (byte_addr_c >= IO_BASE) && io_full_in;
`else
    logic unused_io_full;
    assign unused_io_full = io_full_in;
    assign io_stall_c     = 1'b0;
`endif

    // Next-state, byte sequencing, read assembly and registered-output values
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        n_d          = n_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        asm_d        = asm_q;
        ram_a_d      = ram_a_q;
        ram_wr_d     = 1'b0;
        ram_dout_d   = '0;
        if_done_d    = 1'b0;
        if_inst_d    = if_inst_q;
        mem_done_d   = 1'b0;
        mem_val_d    = mem_val_q;
        accept_mem_c = 1'b0;
        accept_if_c  = 1'b0;
        rd_step_c    = 1'b0;

        mem_req_c   = read_req_in | write_req_in;
        byte_addr_c = addr_q + ADDR_W'(cnt_q);
        wbyte_c     = BYTE_W'(wdata_q >> {cnt_q, 3'b000});
        asm_shift_c = {ram_din_in, asm_q[DATA_W-1:BYTE_W]};
        pad_sh_c    = {CNT_W'(CNT_W'(4) - n_q), 3'b000};
        n_last_c    = n_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (mem_req_c)      accept_mem_c = 1'b1;
                else if (if_req_in) accept_if_c  = 1'b1;
            end
            ST_IF_RD: begin
                if (mem_req_c)       accept_mem_c = 1'b1;
                else if (!if_req_in) state_d      = ST_IDLE;
                else                 rd_step_c    = 1'b1;
            end
            ST_MEM_RD: rd_step_c = 1'b1;
            ST_MEM_WR: begin
                if (cnt_q < n_q) begin
                    ram_a_d = byte_addr_c;
                    if (!io_stall_c) begin
                        ram_wr_d   = 1'b1;
                        ram_dout_d = wbyte_c;
                        cnt_d      = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d    = ST_GAP;
                    mem_done_d = 1'b1;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Reads: address byte k at count k, capture it two counts later
        if (rd_step_c) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q < n_q)         ram_a_d = byte_addr_c;
            if (cnt_q >= CNT_W'(2))  asm_d   = asm_shift_c;
            if (cnt_q == n_last_c) begin
                state_d = ST_GAP;
                if (state_q == ST_IF_RD) begin
                    if_done_d = 1'b1;
                    if_inst_d = asm_shift_c;
                end else begin
                    mem_done_d = 1'b1;
                    mem_val_d  = asm_shift_c >> pad_sh_c;
                end
            end
        end

        if (accept_mem_c) begin
            state_d = write_req_in ? ST_MEM_WR : ST_MEM_RD;
            cnt_d   = '0;
            n_d     = len_bytes(mem_len_in);
            addr_d  = mem_addr_in;
            wdata_d = mem_val_in;
            asm_d   = '0;
        end else if (accept_if_c) begin
            state_d = ST_IF_RD;
            cnt_d   = '0;
            n_d     = CNT_W'(4);
            addr_d  = if_addr_in;
            asm_d   = '0;
        end

        if ((state_d == ST_MEM_RD) || (state_d == ST_MEM_WR) || mem_done_d)
            busy_d = BUSY_MEM;
        else if ((state_d == ST_IF_RD) || if_done_d)
            busy_d = BUSY_IF;
        else
            busy_d = BUSY_IDLE;
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            asm_q      <= '0;
            ram_a_q    <= '0;
            ram_wr_q   <= 1'b0;
            ram_dout_q <= '0;
            if_done_q  <= 1'b0;
            if_inst_q  <= '0;
            mem_done_q <= 1'b0;
            mem_val_q  <= '0;
            busy_q     <= BUSY_IDLE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            asm_q      <= asm_d;
            ram_a_q    <= ram_a_d;
            ram_wr_q   <= ram_wr_d;
            ram_dout_q <= ram_dout_d;
            if_done_q  <= if_done_d;
            if_inst_q  <= if_inst_d;
            mem_done_q <= mem_done_d;
            mem_val_q  <= mem_val_d;
            busy_q     <= busy_d;
        end
    end

    assign if_done_out      = if_done_q;
    assign if_inst_out      = if_inst_q;
    assign mem_done_out     = mem_done_q;
    assign mem_val_read_out = mem_val_q;
    assign busy_out         = busy_q;
    assign ram_a_out        = ram_a_q;
    assign ram_wr_out       = ram_wr_q;
    assign ram_dout_out     = ram_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed vector table, hand sequences for
// preemption/arbitration/flush/reset/I-O stall, and random traffic against a byte-array model.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        if_done_out;
    logic [31:0] if_inst_out;
    logic        read_req_in;
    logic        write_req_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_val_in;
    logic [2:0]  mem_len_in;
    logic        mem_done_out;
    logic [31:0] mem_val_read_out;
    logic [1:0]  busy_out;
    logic [7:0]  ram_din_in;
    logic [31:0] ram_a_out;
    logic        ram_wr_out;
    logic [7:0]  ram_dout_out;
    logic        io_full_in;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in),
        .if_done_out(if_done_out), .if_inst_out(if_inst_out),
        .read_req_in(read_req_in), .write_req_in(write_req_in),
        .mem_addr_in(mem_addr_in), .mem_val_in(mem_val_in), .mem_len_in(mem_len_in),
        .mem_done_out(mem_done_out), .mem_val_read_out(mem_val_read_out),
        .busy_out(busy_out), .ram_din_in(ram_din_in), .ram_a_out(ram_a_out),
        .ram_wr_out(ram_wr_out), .ram_dout_out(ram_dout_out), .io_full_in(io_full_in)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Byte RAM model (64 KiB window, low address bits); data returns the cycle after its address
    logic [7:0]  ram_m [0:65535];
    logic        pre_we = 1'b0;
    logic [15:0] pre_a  = '0;
    logic [7:0]  pre_d  = '0;
    always @(posedge clk_in) begin
        ram_din_in <= ram_m[ram_a_out[15:0]];
        if (pre_we)          ram_m[pre_a] <= pre_d;
        else if (ram_wr_out) ram_m[ram_a_out[15:0]] <= ram_dout_out;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte count implied by a length code
    function automatic int nb(input logic [2:0] len);
        case (len)
            3'b000:  return 1;
            3'b001:  return 2;
            default: return 4;
        endcase
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk_in);
        pre_we = 1'b1; pre_a = a[15:0]; pre_d = d;
        @(negedge clk_in);
        pre_we = 1'b0;
    endtask

    // Per-cycle trace of one request, indexed by cycles after the accept edge
    logic [31:0] tr_a    [0:15];
    logic        tr_wr   [0:15];
    logic [7:0]  tr_d    [0:15];
    logic [1:0]  tr_busy [0:15];

    task automatic run_req(input bit is_if, input bit is_wr, input logic [31:0] addr,
                           input logic [2:0] len, input logic [31:0] wdata, input int n_full,
                           output int lat, output logic [31:0] val);
        int acc;
        @(negedge clk_in);
        io_full_in = (n_full > 0);
        if (is_if) begin
            if_req_in = 1'b1; if_addr_in = addr;
        end else begin
            read_req_in = !is_wr; write_req_in = is_wr;
            mem_addr_in = addr; mem_len_in = len; mem_val_in = wdata;
        end
        @(negedge clk_in);
        acc = cyc;
        lat = -1;
        val = '0;
        for (int i = 0; i < 16; i++) begin
            tr_a[i]    = ram_a_out;
            tr_wr[i]   = ram_wr_out;
            tr_d[i]    = ram_dout_out;
            tr_busy[i] = busy_out;
            io_full_in = (i < n_full);
            if (is_if ? if_done_out : mem_done_out) begin
                lat = cyc - acc;
                val = is_if ? if_inst_out : mem_val_read_out;
                break;
            end
            @(negedge clk_in);
        end
        if_req_in = 1'b0; read_req_in = 1'b0; write_req_in = 1'b0; io_full_in = 1'b0;
    endtask

    typedef struct {
        bit          is_if;
        bit          is_wr;
        logic [31:0] addr;
        logic [2:0]  len;
        logic [31:0] wdata;
        int          exp_lat;
        logic [31:0] exp_val;
    } vec_t;

    vec_t        vecs [12];
    logic [7:0]  shadow [0:63];
    logic [2:0]  lens [5];

    initial begin
        int          lat, n, off, kind, d, found, ifd, md, a_at3, ifo;
        logic [31:0] val, wd, expv, busy_at1, inst;
        logic [2:0]  lenr;

        rst_in = 1'b1; if_req_in = 1'b0; if_addr_in = '0; read_req_in = 1'b0;
        write_req_in = 1'b0; mem_addr_in = '0; mem_val_in = '0; mem_len_in = '0;
        io_full_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check("reset_ram_a", ram_a_out, 32'h0);
        check("reset_ctl", {24'h0, busy_out, if_done_out, mem_done_out, ram_wr_out, 3'b0}, 32'h0);
        check("reset_dout", {24'h0, ram_dout_out}, 32'h0);
        check("reset_inst", if_inst_out, 32'h0);
        check("reset_mval", mem_val_read_out, 32'h0);
        rst_in = 1'b0;

        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h10); poke(32'h103, 8'h00);
        poke(32'h2000, 8'hF0); poke(32'hFFFF_FFFF, 8'h11); poke(32'h0, 8'h22);
        poke(32'h4002, 8'h9A); poke(32'h4003, 8'hBC);

        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0100, 3'b011, 32'h0,          6, 32'h0010_0513};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_2000, 3'b000, 32'h0,          3, 32'h0000_00F0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_3FFC, 3'b011, 32'hDEAD_BEEF,  5, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0000_3FFC, 3'b011, 32'h0,          6, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_3FFD, 3'b001, 32'h0,          4, 32'h0000_ADBE};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_4000, 3'b001, 32'h1234_5678,  3, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_3FFE, 3'b111, 32'h0,          6, 32'h5678_DEAD};
        vecs[7]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 3'b001, 32'h0,          4, 32'h0000_2211};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_5000, 3'b000, 32'hAABB_CCDD,  2, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0000_4000, 3'b010, 32'h0,          6, 32'hBC9A_5678};
        vecs[10] = '{1'b0, 1'b0, 32'h0000_5000, 3'b000, 32'h0,          3, 32'h0000_00DD};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_3FFC, 3'b000, 32'h0,          6, 32'hDEAD_BEEF};

        for (int i = 0; i < 12; i++) begin
            run_req(vecs[i].is_if, vecs[i].is_wr, vecs[i].addr, vecs[i].len, vecs[i].wdata, 0, lat, val);
            n = vecs[i].is_if ? 4 : nb(vecs[i].len);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            if (!vecs[i].is_wr) check($sformatf("v%0d_val", i), val, vecs[i].exp_val);
            check($sformatf("v%0d_busy0", i), {30'h0, tr_busy[0]}, vecs[i].is_if ? 32'h1 : 32'h2);
            check($sformatf("v%0d_wr0", i), {31'h0, tr_wr[0]}, 32'h0);
            for (int k = 0; k < n; k++) begin
                check($sformatf("v%0d_a%0d", i, k), tr_a[1+k], vecs[i].addr + 32'(k));
                check($sformatf("v%0d_wr%0d", i, k), {31'h0, tr_wr[1+k]}, {31'h0, vecs[i].is_wr});
                if (vecs[i].is_wr)
                    check($sformatf("v%0d_d%0d", i, k), {24'h0, tr_d[1+k]},
                          {24'h0, 8'(vecs[i].wdata >> (8*k))});
            end
        end

        // Fetch preempted at byte 2 by a load, then restarted from byte 0
        @(negedge clk_in);
        if_req_in = 1'b1; if_addr_in = 32'h100;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            if (ram_a_out == 32'h102) begin found = 1; break; end
        end
        check("pre_byte2_seen", 32'(found), 32'h1);
        read_req_in = 1'b1; mem_addr_in = 32'h2000; mem_len_in = 3'b000;
        d = cyc; ifd = 0; md = -1; val = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            if (if_done_out) ifd++;
            if (mem_done_out) begin md = cyc - d; val = mem_val_read_out; break; end
        end
        read_req_in = 1'b0;
        check("pre_mem_lat", 32'(md), 32'h4);
        check("pre_mem_val", val, 32'h0000_00F0);
        check("pre_no_ifdone", 32'(ifd), 32'h0);
        d = cyc; ifo = -1; a_at3 = 0; busy_at1 = '1; inst = '0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_in);
            if (cyc - d == 1) busy_at1 = {30'h0, busy_out};
            if (cyc - d == 3) a_at3 = int'(ram_a_out);
            if (if_done_out) begin ifo = cyc - d; inst = if_inst_out; break; end
        end
        if_req_in = 1'b0;
        check("pre_gap_idle_busy", busy_at1, 32'h0);
        check("pre_restart_a0", 32'(a_at3), 32'h100);
        check("pre_if_lat", 32'(ifo), 32'h8);
        check("pre_if_inst", inst, 32'h0010_0513);

        // IF and MEM together in IDLE: MEM first, IF after the GAP cycle
        @(negedge clk_in);
        if_req_in = 1'b1; if_addr_in = 32'h100;
        read_req_in = 1'b1; mem_addr_in = 32'h2000; mem_len_in = 3'b000;
        d = cyc; md = -1; busy_at1 = '1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            if (cyc - d == 1) busy_at1 = {30'h0, busy_out};
            if (mem_done_out) begin md = cyc - d; break; end
        end
        read_req_in = 1'b0;
        check("both_busy_mem", busy_at1, 32'h2);
        check("both_mem_lat", 32'(md), 32'h4);
        d = cyc; ifo = -1; busy_at1 = '1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_in);
            if (cyc - d == 1) busy_at1 = {30'h0, busy_out};
            if (if_done_out) begin ifo = cyc - d; break; end
        end
        if_req_in = 1'b0;
        check("both_gap_busy", busy_at1, 32'h0);
        check("both_if_lat", 32'(ifo), 32'h8);

        // Branch flush: fetch dropped mid-flight produces no done
        @(negedge clk_in);
        if_req_in = 1'b1; if_addr_in = 32'h100;
        repeat (2) @(negedge clk_in);
        if_req_in = 1'b0;
        ifd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            if (if_done_out) ifd++;
        end
        check("flush_no_done", 32'(ifd), 32'h0);
        check("flush_busy", {30'h0, busy_out}, 32'h0);

        // I/O-region store with the write buffer full for three cycles
        run_req(1'b0, 1'b1, 32'h0003_0000, 3'b000, 32'h0000_00A5, 3, lat, val);
`ifdef MEM_IO_STALL_EN
        check("io_lat", 32'(lat), 32'h5);
        for (int k = 1; k < 4; k++) check($sformatf("io_hold%0d", k), {31'h0, tr_wr[k]}, 32'h0);
        check("io_wr", {31'h0, tr_wr[4]}, 32'h1);
        check("io_d", {24'h0, tr_d[4]}, 32'hA5);
        check("io_a", tr_a[4], 32'h0003_0000);
`else
        check("io_lat", 32'(lat), 32'h2);
        check("io_wr", {31'h0, tr_wr[1]}, 32'h1);
        check("io_d", {24'h0, tr_d[1]}, 32'hA5);
        check("io_a", tr_a[1], 32'h0003_0000);
`endif
        run_req(1'b0, 1'b1, 32'h0000_2004, 3'b000, 32'h0000_0077, 3, lat, val);
        check("ram_full_ignored_lat", 32'(lat), 32'h2);

        // Random traffic in a 64-byte window against the byte-array model
        for (int i = 0; i < 64; i++) begin
            shadow[i] = 8'($urandom);
            poke(32'h6000 + 32'(i), shadow[i]);
        end
        lens[0] = 3'b000; lens[1] = 3'b001; lens[2] = 3'b011; lens[3] = 3'b010; lens[4] = 3'b111;
        for (int r = 0; r < 40; r++) begin
            kind = int'($urandom_range(0, 2));
            lenr = lens[$urandom_range(0, 4)];
            off  = int'($urandom_range(0, 60));
            wd   = $urandom;
            n    = (kind == 0) ? 4 : nb(lenr);
            expv = '0;
            for (int k = 0; k < n; k++) expv = expv | (32'(shadow[off+k]) << (8*k));
            run_req(kind == 0, kind == 2, 32'h6000 + 32'(off), lenr, wd, 0, lat, val);
            if (kind == 2) begin
                for (int k = 0; k < n; k++) shadow[off+k] = 8'(wd >> (8*k));
                check($sformatf("rnd%0d_st_lat", r), 32'(lat), 32'(n + 1));
            end else begin
                check($sformatf("rnd%0d_ld_lat", r), 32'(lat), 32'(n + 2));
                check($sformatf("rnd%0d_val", r), val, expv);
            end
        end

        // Asynchronous reset in the middle of a store
        @(negedge clk_in);
        write_req_in = 1'b1; mem_addr_in = 32'h7000; mem_len_in = 3'b011; mem_val_in = 32'h0102_0304;
        repeat (2) @(negedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        check("arst_ram_a", ram_a_out, 32'h0);
        check("arst_ctl", {24'h0, busy_out, if_done_out, mem_done_out, ram_wr_out, 3'b0}, 32'h0);
        check("arst_dout", {24'h0, ram_dout_out}, 32'h0);
        check("arst_mval", mem_val_read_out, 32'h0);
        @(negedge clk_in);
        write_req_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        md = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            if (mem_done_out) md++;
        end
        check("arst_no_done", 32'(md), 32'h0);
        run_req(1'b0, 1'b0, 32'h0000_2000, 3'b000, 32'h0, 0, lat, val);
        check("arst_after_lat", 32'(lat), 32'h3);
        check("arst_after_val", val, 32'h0000_00F0);
        check("arst_after_a", tr_a[1], 32'h0000_2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
